// File: rtl/clk_window_gen.sv
// -----------------------------------------------------------------------------
// clk_window_gen
//   Programmable strobe generator for the start/stop pair of a downstream cycle
//   counter. An accepted arm latches the configuration, waits delay_i+1 cycles,
//   then emits reps_i windows. Each window is a 1-cycle start_o followed
//   max(width_i,1) cycles later by a 1-cycle stop_o. Consecutive windows are
//   separated so that the next start_o lands gap_i+1 cycles after stop_o.
//   abort closes an open window and ends the sequence with aborted_o set.
//
//   Optional feature macro: CLK_WINDOW_GEN_STATS_EN
//     When defined, adds win_cnt_o, a free-running count of stop_o strobes
//     since reset. It wraps, is not cleared by arm, and includes stops forced
//     by abort.
// -----------------------------------------------------------------------------
module clk_window_gen #(
    parameter int CNT_W = 32,
    parameter int REP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic [CNT_W-1:0] delay_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] gap_i,
    input  logic [REP_W-1:0] reps_i,
    output logic             start_o,
    output logic             stop_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [REP_W-1:0] rep_left_o
`ifdef CLK_WINDOW_GEN_STATS_EN
    ,
    output logic [REP_W-1:0] win_cnt_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_ACTIVE,
        ST_GAP,
        ST_FINISH
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;     // down-counter for delay, width and gap phases
    logic [CNT_W-1:0] r_width_m1;  // latched width_eff - 1
    logic [CNT_W-1:0] r_gap;       // latched gap_i

    logic [CNT_W-1:0] w_width_m1;
    logic             w_timer_zero;
    logic             w_reps_zero;
    logic             w_more_reps;

    // NOTE: width_eff - 1 is formed as (width_i == 0) ? 0 : width_i - 1 so an
    // all-ones width never needs a +1 and the timer can never wrap.
    assign w_width_m1   = (width_i == '0) ? '0 : width_i - CNT_W'(1);
    assign w_timer_zero = (r_timer == '0);
    assign w_reps_zero  = (reps_i == '0);
    assign w_more_reps  = (rep_left_o != '0);

    // Sequencer: state, timer, latched configuration and every registered output.
    // NOTE: asynchronous active-low reset; all state here is updated with
    // non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_width_m1 <= '0;
            r_gap      <= '0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            aborted_o  <= 1'b0;
            rep_left_o <= '0;
`ifdef CLK_WINDOW_GEN_STATS_EN
            win_cnt_o  <= '0;
`endif
        end else begin
            // NOTE: strobes default low every cycle so each one is exactly one
            // clock wide without any explicit clearing state.
            start_o <= 1'b0;
            stop_o  <= 1'b0;
            done_o  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    busy_o <= 1'b0;
                    // arm together with abort is treated as no request
                    if (arm && !abort) begin
                        r_timer    <= delay_i;
                        r_width_m1 <= w_width_m1;
                        r_gap      <= gap_i;
                        rep_left_o <= reps_i;
                        aborted_o  <= 1'b0;
                        busy_o     <= 1'b1;
                        r_state    <= w_reps_zero ? ST_FINISH : ST_DELAY;
                    end
                end

                // DELAY and GAP both count down to the next start_o
                ST_DELAY, ST_GAP: begin
                    if (abort) begin
                        aborted_o <= 1'b1;
                        r_state   <= ST_FINISH;
                    end else if (w_timer_zero) begin
                        start_o    <= 1'b1;
                        rep_left_o <= rep_left_o - REP_W'(1);
                        r_timer    <= r_width_m1;
                        r_state    <= ST_ACTIVE;
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                    end
                end

                // Window open: close it on timeout or abort, never both twice
                ST_ACTIVE: begin
                    if (abort || w_timer_zero) begin
                        stop_o <= 1'b1;
`ifdef CLK_WINDOW_GEN_STATS_EN
                        win_cnt_o <= win_cnt_o + REP_W'(1);
`endif
                        if (abort) begin
                            aborted_o <= 1'b1;
                            r_state   <= ST_FINISH;
                        end else if (w_more_reps) begin
                            r_timer <= r_gap;
                            r_state <= ST_GAP;
                        end else begin
                            r_state <= ST_FINISH;
                        end
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                    end
                end

                // busy_o stays high through the done_o cycle and drops after it
                ST_FINISH: begin
                    done_o  <= 1'b1;
                    r_timer <= '0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_window_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_window_gen
//   Scoreboard bench for clk_window_gen. Each directed sequence pushes its
//   expected strobe events (kind, absolute cycle, side value) into a queue;
//   a negedge monitor pops and compares whenever start_o, stop_o or done_o is
//   seen. Cycle E0 is the posedge that accepts arm; an event "at E0+k" is
//   visible after posedge E0+k.
//   Timing rules used for expectations:
//     start   = E0 + delay + 1
//     stop    = start + max(width,1)
//     next st = stop + gap + 1
//     done    = last stop + 1 (or E0+1 for reps=0, abort-edge+1 in DELAY/GAP)
// -----------------------------------------------------------------------------
module tb_clk_window_gen;

    localparam int CNT_W = 32;
    localparam int REP_W = 16;

    typedef enum int { EV_START = 1, EV_STOP = 2, EV_DONE = 3 } ev_e;

    typedef struct {
        ev_e kind;
        int  cyc;
        int  val;   // rep_left_o for start, aborted_o for done, 0 for stop
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             arm = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] delay_i = '0;
    logic [CNT_W-1:0] width_i = '0;
    logic [CNT_W-1:0] gap_i = '0;
    logic [REP_W-1:0] reps_i = '0;
    logic             start_o, stop_o, busy_o, done_o, aborted_o;
    logic [REP_W-1:0] rep_left_o;
    logic [REP_W-1:0] win_cnt;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    ev_t exp_q[$];

    clk_window_gen #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .abort      (abort),
        .delay_i    (delay_i),
        .width_i    (width_i),
        .gap_i      (gap_i),
        .reps_i     (reps_i),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .aborted_o  (aborted_o),
`ifdef CLK_WINDOW_GEN_STATS_EN
        .win_cnt_o  (win_cnt),
`endif
        .rep_left_o (rep_left_o)
    );

`ifndef CLK_WINDOW_GEN_STATS_EN
    assign win_cnt = '0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_e kind, input int at, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_e kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("spurious_event_kind", kind, 0);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.cyc);
            check("event_value", val, e.val);
        end
    endtask

    // Monitor: compares every observed strobe against the scoreboard head
    always @(negedge clk) begin
        if (rst) begin
            if (start_o && stop_o) check("start_stop_overlap", 1, 0);
            if (start_o) observe(EV_START, int'(rep_left_o));
            if (stop_o)  observe(EV_STOP, 0);
            if (done_o)  observe(EV_DONE, int'(aborted_o));
        end
    end

    // Issue an arm at the next posedge; returns that edge's cycle number as e0.
    // Called and returns at a negedge.
    task automatic do_arm(input int d, input int w, input int g, input int r, output int e0);
        delay_i = CNT_W'(d);
        width_i = CNT_W'(w);
        gap_i   = CNT_W'(g);
        reps_i  = REP_W'(r);
        arm     = 1'b1;
        e0      = cyc + 1;
        @(negedge clk);
        arm     = 1'b0;
        delay_i = '1;
        width_i = '1;
        gap_i   = '1;
        reps_i  = '1;
    endtask

    // Wait until the negedge following posedge number 'edge_n'
    task automatic wait_cycle(input int edge_n);
        for (int i = 0; i < 1000 && cyc < edge_n; i++) @(negedge clk);
    endtask

    // Pulse abort so that it is sampled at posedge 'edge_n'
    task automatic abort_at(input int edge_n);
        wait_cycle(edge_n - 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // Bounded drain: all expected events seen and the block idle again
    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !busy_o) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int e0;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_start", start_o, 0);
        check("rst_stop", stop_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_aborted", aborted_o, 0);
        check("rst_rep_left", rep_left_o, 0);

        // T1: delay=0 width=5 gap=0 reps=1
        do_arm(0, 5, 0, 1, e0);
        push(EV_START, e0 + 1, 0);
        push(EV_STOP,  e0 + 6, 0);
        push(EV_DONE,  e0 + 7, 0);
        check("t1_busy_after_arm", busy_o, 1);
        wait_cycle(e0 + 7);
        check("t1_busy_at_done", busy_o, 1);
        wait_cycle(e0 + 8);
        check("t1_busy_after_done", busy_o, 0);
        drain("t1_drain");

        // T2: delay=3 width=2 gap=4 reps=3
        do_arm(3, 2, 4, 3, e0);
        push(EV_START, e0 + 4,  2);
        push(EV_STOP,  e0 + 6,  0);
        push(EV_START, e0 + 11, 1);
        push(EV_STOP,  e0 + 13, 0);
        push(EV_START, e0 + 18, 0);
        push(EV_STOP,  e0 + 20, 0);
        push(EV_DONE,  e0 + 21, 0);
        wait_cycle(e0 + 1);
        check("t2_rep_left_latched", rep_left_o, 3);
        drain("t2_drain");

        // T3: width=0 behaves as width=1
        do_arm(1, 0, 0, 1, e0);
        push(EV_START, e0 + 2, 0);
        push(EV_STOP,  e0 + 3, 0);
        push(EV_DONE,  e0 + 4, 0);
        drain("t3_drain");

        // T4: reps=0 emits only done
        do_arm(2, 3, 0, 0, e0);
        push(EV_DONE, e0 + 1, 0);
        drain("t4_drain");

        // T5: abort two cycles into ACTIVE closes the window next cycle
        do_arm(0, 10, 0, 1, e0);
        push(EV_START, e0 + 1, 0);
        push(EV_STOP,  e0 + 3, 0);
        push(EV_DONE,  e0 + 4, 1);
        abort_at(e0 + 3);
        drain("t5_drain");

        // T6: abort in GAP suppresses the remaining windows
        do_arm(0, 2, 5, 3, e0);
        push(EV_START, e0 + 1, 2);
        push(EV_STOP,  e0 + 3, 0);
        push(EV_DONE,  e0 + 6, 1);
        abort_at(e0 + 5);
        drain("t6_drain");
        check("t6_aborted_sticky", aborted_o, 1);

        // T7: arm while busy is ignored; accepted arm clears aborted_o
        do_arm(2, 3, 0, 1, e0);
        push(EV_START, e0 + 3, 0);
        push(EV_STOP,  e0 + 6, 0);
        push(EV_DONE,  e0 + 7, 0);
        check("t7_aborted_cleared", aborted_o, 0);
        wait_cycle(e0 + 1);
        reps_i = REP_W'(5);
        delay_i = '0;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("t7_rep_left_unchanged", rep_left_o, 1);
        drain("t7_drain");

        // arm together with abort in IDLE is no arm
        arm = 1'b1;
        abort = 1'b1;
        reps_i = REP_W'(2);
        @(negedge clk);
        arm = 1'b0;
        abort = 1'b0;
        check("arm_abort_busy", busy_o, 0);
        @(negedge clk);
        check("arm_abort_busy_later", busy_o, 0);
        drain("arm_abort_drain");

        // T8: gap=0 gives back-to-back stop/start
        do_arm(0, 1, 0, 2, e0);
        push(EV_START, e0 + 1, 1);
        push(EV_STOP,  e0 + 2, 0);
        push(EV_START, e0 + 3, 0);
        push(EV_STOP,  e0 + 4, 0);
        push(EV_DONE,  e0 + 5, 0);
        drain("t8_drain");

        // Stats sequence from a fresh reset: reps=4
        apply_reset();
        do_arm(0, 1, 1, 4, e0);
        push(EV_START, e0 + 1,  3);
        push(EV_STOP,  e0 + 2,  0);
        push(EV_START, e0 + 4,  2);
        push(EV_STOP,  e0 + 5,  0);
        push(EV_START, e0 + 7,  1);
        push(EV_STOP,  e0 + 8,  0);
        push(EV_START, e0 + 10, 0);
        push(EV_STOP,  e0 + 11, 0);
        push(EV_DONE,  e0 + 12, 0);
        drain("stats_drain");
`ifdef CLK_WINDOW_GEN_STATS_EN
        check("stats_win_cnt_4", win_cnt, 4);
`endif

        // T9: asynchronous reset mid-ACTIVE clears outputs without an edge
        do_arm(0, 10, 0, 2, e0);
        push(EV_START, e0 + 1, 1);
        wait_cycle(e0 + 3);
        check("t9_busy_before_rst", busy_o, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t9_start", start_o, 0);
        check("t9_stop", stop_o, 0);
        check("t9_busy", busy_o, 0);
        check("t9_done", done_o, 0);
        check("t9_aborted", aborted_o, 0);
        check("t9_rep_left", rep_left_o, 0);
`ifdef CLK_WINDOW_GEN_STATS_EN
        check("t9_win_cnt", win_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("t9_no_stop_after_reset", exp_q.size(), 0);
        check("t9_idle_after_reset", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
